// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_pkg
//  Brief    : Shared definitions for the UART receive path: state encoding,
//             default oversampling / frame length and the majority voter.
//  Revision : 1.0  initial release
// ============================================================================
package uart_rx_pkg;

  // Defaults shared by the start detector, receiver FSM and shift register.
  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int FRAME_BITS_DEFAULT = 10;

  // Start-detector state encoding.
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_START_CHECK = 2'd1,
    ST_FRAME       = 2'd2,
    ST_WAIT_HIGH   = 2'd3
  } rx_state_t;

  // Two-out-of-three vote used on the mid-bit samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_start_detector_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_start_detector_if
//  Brief    : Serial line input and the start/sample/error pulses that the
//             start detector hands to the receiver control FSM.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_rx_start_detector_if;

  logic Serial_In;      // asynchronous UART line, idle high
  logic DeStart_Bit;    // pulse: start bit confirmed
  logic Sample_Strobe;  // pulse: Sampled_Bit holds a new frame bit
  logic Sampled_Bit;    // voted bit value, held between strobes
  logic False_Start;    // pulse: start bit rejected as a glitch
  logic Framing_Error;  // pulse: stop bit sampled low
  logic Busy;           // detector is not idle

  // Detector side: consumes the line, produces the pulses.
  modport master (
    input  Serial_In,
    output DeStart_Bit,
    output Sample_Strobe,
    output Sampled_Bit,
    output False_Start,
    output Framing_Error,
    output Busy
  );

  // System side: supplies the line, consumes the pulses.
  modport slave (
    output Serial_In,
    input  DeStart_Bit,
    input  Sample_Strobe,
    input  Sampled_Bit,
    input  False_Start,
    input  Framing_Error,
    input  Busy
  );

endinterface
`default_nettype wire

// File: rtl/line_synchronizer.sv
`default_nettype none
// ============================================================================
//  Module   : line_synchronizer
//  Brief    : Multi-flop synchronizer for the asynchronous serial line.
//             Resets to 1 (idle line level) so release never looks like an
//             edge.
//  Revision : 1.0  initial release
// ============================================================================
module line_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  // Shift the raw line through STAGES flops; the last one is the safe copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_start_detector.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_start_detector
//  Brief    : UART receive front end. Synchronizes the line, detects the
//             falling edge of a start bit, qualifies it with a mid-bit
//             majority vote and then strobes out voted mid-bit samples of
//             every frame bit. Flags false starts and low stop bits.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_start_detector
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
  parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     Baud_Clk,
  input  logic                     Reset,
  uart_rx_start_detector_if.master rx
);

  localparam int PW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int SW = $clog2(SYNC_STAGES + 1);

  // Vote window around the bit centre H: samples at H-1, H, vote at H+1,
  // act on the registered vote at H+2.
  localparam logic [PW-1:0] c_PH_LO    = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] c_PH_MID   = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] c_PH_VOTE  = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [PW-1:0] c_PH_ACT   = PW'(OVERSAMPLE / 2 + 2);
  localparam logic [PW-1:0] c_PH_LAST  = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] c_PH_FIRST = PW'(1);
  localparam logic [BW-1:0] c_LAST_BIT = BW'(FRAME_BITS);
  localparam logic [SW-1:0] c_SETTLED  = SW'(SYNC_STAGES);

  logic            w_line;
  logic            w_line_ok;
  logic            w_edge;
  logic            w_vote;

  rx_state_t       r_state;
  logic [PW-1:0]   r_phase;
  logic [BW-1:0]   r_bitcnt;
  logic [SW-1:0]   r_settle;
  logic            r_prev_line;
  logic            r_armed;
  logic            r_s_lo;
  logic            r_s_mid;
  logic            r_vote;

  logic            r_destart;
  logic            r_strobe;
  logic            r_sampled;
  logic            r_false;
  logic            r_ferr;
  logic            r_busy;

  line_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (Baud_Clk),
    .rst_n   (Reset),
    .i_async (rx.Serial_In),
    .o_sync  (w_line)
  );

  // The synchronizer's reset ones are not real line data; only trust the
  // line once every stage has been refilled from Serial_In.
  assign w_line_ok = (r_settle == c_SETTLED);

  // A start needs a genuine high before the fall, so a line held low across
  // reset release cannot trigger.
  assign w_edge = r_armed & r_prev_line & ~w_line;

  // Vote formed from the two stored samples and the current one.
  assign w_vote = maj3(r_s_lo, r_s_mid, w_line);

  // Track the previous line level and arm edge detection once the line has
  // been seen high with valid synchronizer contents.
  always_ff @(posedge Baud_Clk) begin
    if (!Reset) begin
      r_settle    <= '0;
      r_prev_line <= 1'b1;
      r_armed     <= 1'b0;
    end else begin
      if (r_settle != c_SETTLED) begin
        r_settle <= r_settle + 1'b1;
      end
      r_prev_line <= w_line;
      if (w_line_ok && w_line) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Detector FSM: bit timing counters, mid-bit voting and registered pulses.
  always_ff @(posedge Baud_Clk) begin
    if (!Reset) begin
      r_state   <= ST_IDLE;
      r_phase   <= '0;
      r_bitcnt  <= '0;
      r_s_lo    <= 1'b1;
      r_s_mid   <= 1'b1;
      r_vote    <= 1'b1;
      r_destart <= 1'b0;
      r_strobe  <= 1'b0;
      r_sampled <= 1'b1;
      r_false   <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      // Pulses are single-cycle unless re-asserted below.
      r_destart <= 1'b0;
      r_strobe  <= 1'b0;
      r_false   <= 1'b0;
      r_ferr    <= 1'b0;

      // Phase free-runs while a frame is in progress; bitcnt advances on
      // every phase wrap and never needs to wrap itself.
      if (r_state != ST_IDLE) begin
        r_phase <= r_phase + 1'b1;
        if (r_phase == c_PH_LAST) begin
          r_bitcnt <= r_bitcnt + 1'b1;
        end
        if (r_phase == c_PH_LO) begin
          r_s_lo <= w_line;
        end
        if (r_phase == c_PH_MID) begin
          r_s_mid <= w_line;
        end
        if (r_phase == c_PH_VOTE) begin
          r_vote <= w_vote;
        end
      end else begin
        r_phase  <= '0;
        r_bitcnt <= '0;
      end

      case (r_state)
        ST_IDLE: begin
          // Edge cycle is tick 0, so the next cycle is already phase 1.
          if (w_edge) begin
            r_state  <= ST_START_CHECK;
            r_phase  <= c_PH_FIRST;
            r_bitcnt <= '0;
            r_busy   <= 1'b1;
          end
        end

        ST_START_CHECK: begin
          if (r_phase == c_PH_VOTE) begin
            if (!w_vote) begin
              r_destart <= 1'b1;
            end else begin
              r_false <= 1'b1;
            end
          end
          if (r_phase == c_PH_ACT) begin
            if (!r_vote) begin
              r_state <= ST_FRAME;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end

        ST_FRAME: begin
          // Falling edges are ignored here; only the vote matters.
          if (r_phase == c_PH_VOTE && r_bitcnt != '0) begin
            r_strobe  <= 1'b1;
            r_sampled <= w_vote;
            if (r_bitcnt == c_LAST_BIT && !w_vote) begin
              r_ferr <= 1'b1;
            end
          end
          // Leave right after the stop strobe so the next start edge can
          // land as early as possible.
          if (r_phase == c_PH_ACT && r_bitcnt == c_LAST_BIT) begin
            if (r_vote) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_WAIT_HIGH;
            end
          end
        end

        ST_WAIT_HIGH: begin
          // A break holds us here; the line must return high first.
          if (w_line) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx.DeStart_Bit   = r_destart;
  assign rx.Sample_Strobe = r_strobe;
  assign rx.Sampled_Bit   = r_sampled;
  assign rx.False_Start   = r_false;
  assign rx.Framing_Error = r_ferr;
  assign rx.Busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_start_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_start_detector
//  Brief    : Self-checking bench for uart_rx_start_detector. Expected pulses
//             are queued when a frame is driven and matched against the
//             pulses the detector emits.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_start_detector;

  localparam int OS = 16;
  localparam int FB = 10;

  localparam int K_DESTART = 1;
  localparam int K_FALSE   = 2;
  localparam int K_STROBE  = 3;
  localparam int K_FERR    = 4;

  typedef struct {
    int kind;
    int cyc;
    int bitv;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  ev_t  exp_q[$];

  uart_rx_start_detector_if bus ();

  uart_rx_start_detector #(
    .OVERSAMPLE  (OS),
    .FRAME_BITS  (FB),
    .SYNC_STAGES (2)
  ) dut (
    .Baud_Clk (clk),
    .Reset    (rst_n),
    .rx       (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic void push(input int k, input int c, input int b);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.bitv = b;
    exp_q.push_back(e);
  endfunction

  task automatic observe(input int kind, input int bitv);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk_eq("unexpected_pulse", kind, 0);
    end else begin
      e = exp_q.pop_front();
      chk_eq("pulse_kind", kind, e.kind);
      chk_eq("pulse_cycle", cyc, e.cyc);
      if (kind == K_STROBE) chk_eq("sampled_bit", bitv, e.bitv);
    end
  endtask

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.DeStart_Bit)   observe(K_DESTART, 0);
    if (bus.False_Start)   observe(K_FALSE, 0);
    if (bus.Sample_Strobe) observe(K_STROBE, int'(bus.Sampled_Bit));
    if (bus.Framing_Error) observe(K_FERR, 0);
  end

  task automatic idle(input int n);
    bus.Serial_In = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame: start, 8 data LSB-first, even parity, stop.
  // nz_bit/nz_ph flip the line for one tick; cut>0 asserts reset at that tick.
  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input int nz_bit, input int nz_ph, input int cut);
    logic [10:0] fb;
    int t0;
    int rel;
    int lim;
    logic v;
    fb  = {stop_v, ^d, d, 1'b0};
    lim = (cut > 0) ? cut : 100000;
    t0  = 0;
    for (int b = 0; b < FB + 1; b++) begin
      for (int p = 0; p < OS; p++) begin
        @(negedge clk);
        if (b == 0 && p == 0) begin
          t0 = cyc + 2;
          if (10 < lim) push(K_DESTART, t0 + 10, 0);
          for (int k = 1; k <= FB; k++)
            if (OS * k + 10 < lim) push(K_STROBE, t0 + OS * k + 10, int'(fb[k]));
          if (!stop_v && (OS * FB + 10 < lim)) push(K_FERR, t0 + OS * FB + 10, 0);
        end
        rel = cyc - t0;
        if (cut > 0 && rel == cut) begin
          rst_n = 1'b0;
          return;
        end
        if (rel == -1 || rel == 0) chk_eq("busy_before_edge", int'(bus.Busy), 0);
        if (rel == 1) chk_eq("busy_after_edge", int'(bus.Busy), 1);
        if (rel >= OS + 15 && (rel % OS) == 15)
          chk_eq("sampled_hold", int'(bus.Sampled_Bit), int'(fb[rel / OS]));
        if (rel == OS * FB + 10) chk_eq("busy_at_stop", int'(bus.Busy), 1);
        if (rel == OS * FB + 11) chk_eq("busy_after_stop", int'(bus.Busy), stop_v ? 0 : 1);
        v = fb[b];
        if (b == nz_bit && p == nz_ph) v = ~v;
        bus.Serial_In = v;
      end
    end
  endtask

  // Line low for four ticks only, then high until the next frame.
  task automatic glitch();
    int t0;
    @(negedge clk);
    t0 = cyc + 2;
    bus.Serial_In = 1'b0;
    push(K_FALSE, t0 + 10, 0);
    for (int i = 1; i < 12; i++) begin
      @(negedge clk);
      if (cyc == t0 + 9) chk_eq("busy_glitch", int'(bus.Busy), 1);
      bus.Serial_In = (i < 4) ? 1'b0 : 1'b1;
    end
  endtask

  initial begin
    bus.Serial_In = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_busy",    int'(bus.Busy), 0);
    chk_eq("rst_destart", int'(bus.DeStart_Bit), 0);
    chk_eq("rst_strobe",  int'(bus.Sample_Strobe), 0);
    chk_eq("rst_sampled", int'(bus.Sampled_Bit), 1);
    chk_eq("rst_false",   int'(bus.False_Start), 0);
    chk_eq("rst_ferr",    int'(bus.Framing_Error), 0);
    rst_n = 1'b1;
    idle(10);

    // Clean 0x55 frame.
    send_frame(8'h55, 1'b1, -1, 0, 0);
    idle(20);

    // Glitch followed by a frame whose edge lands at tick 12.
    glitch();
    send_frame(8'hC6, 1'b1, -1, 0, 0);
    idle(20);

    // Single-tick noise at phase 8 of data bit 3.
    send_frame(8'h5A, 1'b1, 4, 8, 0);
    idle(20);

    // Low stop bit followed by a 40-tick break.
    send_frame(8'h3C, 1'b0, -1, 0, 0);
    repeat (40) @(negedge clk);
    chk_eq("busy_in_break", int'(bus.Busy), 1);
    bus.Serial_In = 1'b1;
    repeat (6) @(negedge clk);
    chk_eq("busy_after_break", int'(bus.Busy), 0);
    idle(10);
    send_frame(8'h81, 1'b1, -1, 0, 0);
    idle(20);

    // Reset at tick 80, released at tick 85 with the line low.
    send_frame(8'h55, 1'b1, -1, 0, 80);
    bus.Serial_In = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_eq("busy_after_abort", int'(bus.Busy), 0);
    chk_eq("sampled_after_abort", int'(bus.Sampled_Bit), 1);
    repeat (40) @(negedge clk);
    chk_eq("busy_low_line", int'(bus.Busy), 0);
    idle(20);
    send_frame(8'h2D, 1'b1, -1, 0, 0);
    idle(20);

    // Back-to-back frames with no idle gap.
    send_frame(8'hA3, 1'b1, -1, 0, 0);
    send_frame(8'h0F, 1'b1, -1, 0, 0);
    idle(30);

    chk_eq("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
